debug_dma_host_seq: RTL and testbench

Host-side sequencer for the on-chip debug DMA engine. It takes one transfer request from the debug host link and programs the target thread's DMA address and control registers through the command interface. It then waits for that thread's DMA completion. For read transfers it drains the result words from the DMA write buffer, checks their parity, and streams them to the host TX path. It is the initiator/reader counterpart of the DMA engine: it writes the command interface and reads the write buffer.

---
 rtl/debug_dma_host_seq.sv | 190 +++++++++++++++++++
 tb/tb_debug_dma_host_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dma_host_seq.sv
// Host-side sequencer for the debug DMA engine: programs one DMA command, waits for
// that thread's completion, and optionally streams the write-buffer result to the host.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | ready for a host request
// WR_ADDR   | strobe address/tid into the command interface
// WR_CTRL   | strobe buf_addr/count/op into the command interface
// WAIT_DONE | wait for dma_done from the latched thread
// DRAIN     | read count+1 buffer words and stream them to tx
`timescale 1ns/1ps
module debug_dma_host_seq #(
    parameter int NTHREADIDMSB = 5,
    parameter int DMABUFMSB    = 9
) (
    input  logic                    gclk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NTHREADIDMSB:0]   req_tid,
    input  logic [29:0]             req_addr,
    input  logic [DMABUFMSB:0]      req_buf_addr,
    input  logic [DMABUFMSB:0]      req_count,
    input  logic                    req_rd,
    output logic [NTHREADIDMSB:0]   cmd_tid,
    output logic [29:0]             cmd_addr,
    output logic                    cmd_addr_parity,
    output logic                    cmd_addr_we,
    output logic [DMABUFMSB:0]      cmd_buf_addr,
    output logic [DMABUFMSB:0]      cmd_count,
    output logic                    cmd_op,
    output logic                    cmd_ctrl_parity,
    output logic                    cmd_ctrl_we,
    input  logic                    dma_done,
    input  logic [NTHREADIDMSB:0]   dma_done_tid,
    output logic [DMABUFMSB:0]      wb_addr,
    output logic                    wb_we,
    input  logic [31:0]             wb_data,
    input  logic                    wb_parity,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [31:0]             tx_data,
    output logic                    tx_last,
    output logic                    perr,
    output logic                    busy
);

    localparam int CW = DMABUFMSB + 2;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_CTRL, WAIT_DONE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [NTHREADIDMSB:0]   tid_q;
    logic [29:0]             addr_q;
    logic [DMABUFMSB:0]      buf_q;
    logic [DMABUFMSB:0]      count_q;
    logic                    rd_q;
    logic                    op_q;
    logic                    perr_q;
    logic [DMABUFMSB:0]      rd_ptr_q;
    logic [CW-1:0]           rd_left_q;
    logic [CW-1:0]           tx_left_q;
    logic                    rd_pend_q;
    logic [31:0]             fifo_q [2];
    logic                    fifo_wr_q;
    logic                    fifo_rd_q;
    logic [1:0]              fifo_occ_q;

    logic accept, done_hit, in_drain, issue, pop, push, fifo_pop, last_pop;

    assign accept   = (state_q == IDLE) && req_valid;
    assign done_hit = (state_q == WAIT_DONE) && dma_done && (dma_done_tid == tid_q);
    assign in_drain = (state_q == DRAIN);
    // Reads in flight count against FIFO space so a stalled tx never overflows it.
    assign issue    = in_drain && (rd_left_q != '0) && ((fifo_occ_q + {1'b0, rd_pend_q}) < 2'd2);
    assign tx_valid = in_drain && ((fifo_occ_q != 2'd0) || rd_pend_q);
    assign pop      = tx_valid && tx_ready;
    // A returning word bypasses the FIFO when it is empty and taken immediately.
    assign push     = rd_pend_q && !((fifo_occ_q == 2'd0) && pop);
    assign fifo_pop = pop && (fifo_occ_q != 2'd0);
    assign last_pop = pop && (tx_left_q == CW'(1));

    assign tx_data  = !tx_valid ? 32'h0 :
                      (fifo_occ_q != 2'd0) ? fifo_q[fifo_rd_q] : wb_data;
    assign tx_last  = tx_valid && (tx_left_q == CW'(1));

    assign cmd_tid         = tid_q;
    assign cmd_addr        = addr_q;
    assign cmd_addr_parity = ^addr_q;
    assign cmd_buf_addr    = buf_q;
    assign cmd_count       = count_q;
    assign cmd_op          = op_q;
    assign cmd_ctrl_parity = ^{buf_q, count_q, op_q};
    assign wb_addr         = rd_ptr_q;
    assign wb_we           = 1'b0;
    assign perr            = perr_q;
    assign busy            = !req_ready;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        cmd_addr_we = 1'b0;
        cmd_ctrl_we = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = WR_ADDR;
            end
            WR_ADDR: begin
                cmd_addr_we = 1'b1;
                state_d     = WR_CTRL;
            end
            WR_CTRL: begin
                cmd_ctrl_we = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_hit) state_d = rd_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (last_pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            tid_q      <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            count_q    <= '0;
            rd_q       <= 1'b0;
            op_q       <= 1'b0;
            perr_q     <= 1'b0;
            rd_ptr_q   <= '0;
            rd_left_q  <= '0;
            tx_left_q  <= '0;
            rd_pend_q  <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_occ_q <= 2'd0;
        end else begin
            if (accept) begin
                tid_q   <= req_tid;
                addr_q  <= req_addr;
                buf_q   <= req_buf_addr;
                count_q <= req_count;
                rd_q    <= req_rd;
                op_q    <= 1'b1;
                perr_q  <= 1'b0;
            end else if (rd_pend_q && ((^wb_data) != wb_parity)) begin
                perr_q <= 1'b1;
            end

            if (done_hit) begin
                rd_ptr_q  <= buf_q;
                rd_left_q <= {1'b0, count_q} + CW'(1);
                tx_left_q <= {1'b0, count_q} + CW'(1);
            end else begin
                if (issue) begin
                    rd_ptr_q  <= rd_ptr_q + (DMABUFMSB+1)'(1);
                    rd_left_q <= rd_left_q - CW'(1);
                end
                if (pop) tx_left_q <= tx_left_q - CW'(1);
            end

            rd_pend_q <= issue;

            if (push) begin
                fifo_q[fifo_wr_q] <= wb_data;
                fifo_wr_q         <= ~fifo_wr_q;
            end
            if (fifo_pop) fifo_rd_q <= ~fifo_rd_q;
            case ({push, fifo_pop})
                2'b10:   fifo_occ_q <= fifo_occ_q + 2'd1;
                2'b01:   fifo_occ_q <= fifo_occ_q - 2'd1;
                default: fifo_occ_q <= fifo_occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dma_host_seq.sv
// Directed bench for debug_dma_host_seq: command strobes, done filtering, drain
// streaming with stalls and wrap, parity error capture and mid-stream reset.
`timescale 1ns/1ps
module tb_debug_dma_host_seq;

    logic        gclk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_tid = '0;
    logic [29:0] req_addr = '0;
    logic [9:0]  req_buf_addr = '0;
    logic [9:0]  req_count = '0;
    logic        req_rd = 1'b0;
    logic [5:0]  cmd_tid;
    logic [29:0] cmd_addr;
    logic        cmd_addr_parity, cmd_addr_we;
    logic [9:0]  cmd_buf_addr, cmd_count;
    logic        cmd_op, cmd_ctrl_parity, cmd_ctrl_we;
    logic        dma_done = 1'b0;
    logic [5:0]  dma_done_tid = '0;
    logic [9:0]  wb_addr;
    logic        wb_we;
    logic [31:0] wb_data = '0;
    logic        wb_parity = 1'b0;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] tx_data;
    logic        tx_last, perr, busy;

    logic        bad_en = 1'b0;
    logic [9:0]  bad_addr = '0;
    int          checks = 0;
    int          errors = 0;

    debug_dma_host_seq dut (
        .gclk(gclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid),
        .req_addr(req_addr), .req_buf_addr(req_buf_addr), .req_count(req_count),
        .req_rd(req_rd),
        .cmd_tid(cmd_tid), .cmd_addr(cmd_addr), .cmd_addr_parity(cmd_addr_parity),
        .cmd_addr_we(cmd_addr_we), .cmd_buf_addr(cmd_buf_addr), .cmd_count(cmd_count),
        .cmd_op(cmd_op), .cmd_ctrl_parity(cmd_ctrl_parity), .cmd_ctrl_we(cmd_ctrl_we),
        .dma_done(dma_done), .dma_done_tid(dma_done_tid),
        .wb_addr(wb_addr), .wb_we(wb_we), .wb_data(wb_data), .wb_parity(wb_parity),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .perr(perr), .busy(busy)
    );

    always #5 gclk = ~gclk;

    function automatic logic [31:0] word(input logic [9:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    // Write-buffer memory: synchronous read, optional parity corruption at one address.
    always @(posedge gclk) begin
        wb_data   <= word(wb_addr);
        wb_parity <= (^word(wb_addr)) ^ (bad_en && (wb_addr == bad_addr));
    end

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [5:0] tid, input logic [29:0] addr,
                            input logic [9:0] bufa, input logic [9:0] cnt, input logic rd);
        req_tid = tid; req_addr = addr; req_buf_addr = bufa; req_count = cnt; req_rd = rd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [5:0] tid);
        dma_done = 1'b1;
        dma_done_tid = tid;
        tick();
        dma_done = 1'b0;
    endtask

    // Expects to be called at cycle t+1 with tx_ready held high.
    task automatic drain_full(input string tag, input logic [9:0] bufa, input int cnt);
        logic [9:0] a;
        for (int k = 0; k <= cnt; k++) begin
            a = bufa + 10'(k);
            check({tag, "_wb_addr"}, 32'(wb_addr), 32'(a));
            tick();
            check({tag, "_tx_valid"}, 32'(tx_valid), 32'd1);
            check({tag, "_tx_data"}, tx_data, word(a));
            check({tag, "_tx_last"}, 32'(tx_last), 32'(k == cnt));
        end
        tick();
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        check({tag, "_tx_idle"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] rdy_pat;
        logic        stalled;
        logic [31:0] held;
        int          idx;
        int          cyc;

        rst = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_addr_we", 32'(cmd_addr_we), 32'd0);
        check("rst_ctrl_we", 32'(cmd_ctrl_we), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Write-only request, done at cycle 10
        send_req(6'd3, 30'h1000, 10'd0, 10'd7, 1'b0);
        check("wo_addr_we", 32'(cmd_addr_we), 32'd1);
        check("wo_ctrl_we_c1", 32'(cmd_ctrl_we), 32'd0);
        check("wo_cmd_addr", 32'(cmd_addr), 32'h1000);
        check("wo_addr_par", 32'(cmd_addr_parity), 32'd1);
        check("wo_cmd_tid", 32'(cmd_tid), 32'd3);
        check("wo_busy", 32'(busy), 32'd1);
        tick();
        check("wo_ctrl_we", 32'(cmd_ctrl_we), 32'd1);
        check("wo_addr_we_c2", 32'(cmd_addr_we), 32'd0);
        check("wo_cmd_count", 32'(cmd_count), 32'd7);
        check("wo_cmd_buf", 32'(cmd_buf_addr), 32'd0);
        check("wo_cmd_op", 32'(cmd_op), 32'd1);
        check("wo_ctrl_par", 32'(cmd_ctrl_parity), 32'd0);
        tick();
        check("wo_ctrl_we_c3", 32'(cmd_ctrl_we), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("wo_wait_ready", 32'(req_ready), 32'd0);
        pulse_done(6'd3);
        check("wo_ready_c11", 32'(req_ready), 32'd1);
        check("wo_no_tx", 32'(tx_valid), 32'd0);
        check("wo_addr_hold", 32'(cmd_addr), 32'h1000);

        // Done while idle is ignored
        pulse_done(6'd3);
        check("idle_done_ready", 32'(req_ready), 32'd1);

        // Read with wrap, tx_ready high
        send_req(6'd5, 30'h1234, 10'h3FE, 10'd3, 1'b1);
        tick();
        tick();
        pulse_done(6'd5);
        drain_full("rd", 10'h3FE, 3);

        // Same read with stalls
        send_req(6'd5, 30'h1234, 10'h3FE, 10'd3, 1'b1);
        tick();
        tick();
        pulse_done(6'd5);
        rdy_pat = 16'b0110_1001_1011_0011;
        stalled = 1'b0;
        held = '0;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            tx_ready = rdy_pat[cyc % 16];
            if (stalled) begin
                check("st_valid_hold", 32'(tx_valid), 32'd1);
                check("st_data_hold", tx_data, held);
            end
            if (tx_valid) begin
                check("st_data", tx_data, word(10'h3FE + 10'(idx)));
                check("st_last", 32'(tx_last), 32'(idx == 3));
            end
            stalled = tx_valid && !tx_ready;
            held = tx_data;
            if (tx_valid && tx_ready) idx++;
            tick();
            cyc++;
        end
        tx_ready = 1'b1;
        check("st_word_count", 32'(idx), 32'd4);
        check("st_ready_back", 32'(req_ready), 32'd1);
        check("st_no_extra", 32'(tx_valid), 32'd0);

        // Mismatched-tid done is ignored
        send_req(6'd5, 30'h0, 10'h010, 10'd1, 1'b1);
        tick();
        tick();
        pulse_done(6'd2);
        check("tid_ign_ready", 32'(req_ready), 32'd0);
        tick();
        check("tid_ign_tx", 32'(tx_valid), 32'd0);
        check("tid_ign_busy", 32'(busy), 32'd1);
        pulse_done(6'd5);
        drain_full("tid", 10'h010, 1);

        // Bad parity on word 2 of 4
        bad_en = 1'b1;
        bad_addr = 10'h022;
        send_req(6'd1, 30'h0, 10'h020, 10'd3, 1'b1);
        tick();
        tick();
        pulse_done(6'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("par_tx_data", tx_data, word(10'h020 + 10'(k)));
            check("par_perr", 32'(perr), 32'(k == 3));
        end
        tick();
        check("par_perr_sticky", 32'(perr), 32'd1);
        check("par_ready", 32'(req_ready), 32'd1);
        bad_en = 1'b0;
        send_req(6'd4, 30'h3, 10'd0, 10'd0, 1'b0);
        check("par_perr_clr", 32'(perr), 32'd0);
        check("par_addr_par", 32'(cmd_addr_parity), 32'd0);
        tick();
        tick();
        pulse_done(6'd4);
        check("par_wo_ready", 32'(req_ready), 32'd1);

        // Reset mid-drain after two words
        send_req(6'd6, 30'h55, 10'h100, 10'd7, 1'b1);
        tick();
        tick();
        pulse_done(6'd6);
        tick();
        check("mr_w0", tx_data, word(10'h100));
        tick();
        check("mr_w1", tx_data, word(10'h101));
        tick();
        rst = 1'b1;
        #1;
        check("mr_tx_valid", 32'(tx_valid), 32'd0);
        check("mr_req_ready", 32'(req_ready), 32'd1);
        check("mr_wb_addr", 32'(wb_addr), 32'd0);
        check("mr_cmd_addr", 32'(cmd_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mr_idle_tx", 32'(tx_valid), 32'd0);
        send_req(6'd2, 30'h7, 10'h3FF, 10'd1, 1'b1);
        check("mr_new_addr_we", 32'(cmd_addr_we), 32'd1);
        check("mr_new_addr_par", 32'(cmd_addr_parity), 32'd1);
        tick();
        tick();
        pulse_done(6'd2);
        drain_full("mr_new", 10'h3FF, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
